// File: rtl/imem_loader.sv
// imem_loader: boot-time loader packing a header/image/checksum byte stream into instruction memory.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);
   typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} state_t;
   state_t            state;
   logic [1:0]        bc;
   logic [23:0]       sh;
   logic [ADDR_W:0]   n, cnt, cnt_nx;
   logic [31:0]       acc, word;
   logic              take, last, bad;
   assign in_ready = !rst && state != DONE && state != ERR;
   assign take     = in_valid && in_ready;
   assign last     = take && bc == 2'd3;
   assign word     = {sh, in_data};
   assign cnt_nx   = cnt + 1'b1;
   // N must lie in 1..2^ADDR_W; compare one bit wider so 2^ADDR_W itself is representable
   assign bad      = word == 32'd0 || {1'b0, word} > (33'd1 << ADDR_W);
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HDR;
         bc       <= '0;
         sh       <= '0;
         n        <= '0;
         cnt      <= '0;
         acc      <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         im_we    <= 1'b0;
         done     <= state == DONE;
         err      <= state == ERR;
         cpu_hold <= state != DONE;
         if (take) begin
            sh <= {sh[15:0], in_data};
            bc <= bc + 1'b1;
         end
         if (last)
            case (state)
               HDR:
                  if (bad) state <= ERR;
                  else begin
                     n     <= word[ADDR_W:0];
                     cnt   <= '0;
                     acc   <= '0;
                     state <= LOAD;
                  end
               LOAD: begin
                  im_we    <= 1'b1;
                  im_addr  <= cnt[ADDR_W-1:0];
                  im_wdata <= word;
                  acc      <= acc ^ word;
                  cnt      <= cnt_nx;
                  if (cnt_nx == n) state <= CHK;
               end
               CHK:     state <= word == acc ? DONE : ERR;
               default: state <= state;
            endcase
      end
   end
endmodule
